spoofer_avst_sink: RTL

- Avalon-ST sink and checker for the spoofer counter stream.
- Accepts beats with valid/ready handshake (readyLatency 0) and locks onto the first received word.
- Checks every later beat against an incrementing expected value, wrapping modulo 2^DATA_WIDTH.
- Used in spoofer testbenches and on-FPGA loopback; reports beat count, error count and the first mismatch.

---
 rtl/spoofer_avst_sink.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/spoofer_avst_sink.sv
// spoofer_avst_sink: Avalon-ST sink/checker for the spoofer counter stream.
// Locks onto the first received word, then expects an incrementing sequence
// (modulo 2^DATA_WIDTH). Reports beat count, error count and first mismatch.
// Optional macro SPOOFER_AVST_SINK_STALL_EN adds LFSR-driven backpressure.
//
// state  | meaning
// SYNC   | waiting for the first beat to lock onto
// CHECK  | locked, comparing each beat against the expected value
// FLUSH  | one-cycle clear after clr, ready held low
module spoofer_avst_sink #(
    parameter int          DATA_WIDTH = 32,
    parameter int          CNT_WIDTH  = 32,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  ready,
    input  logic                  clr,
    output logic                  locked,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic [CNT_WIDTH-1:0]  error_count,
    output logic                  err_sticky,
    output logic [DATA_WIDTH-1:0] first_err_exp,
    output logic [DATA_WIDTH-1:0] first_err_got
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_CHECK = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                state;
    state_t                state_nxt;
    logic                  state_ready;
    logic                  accept;
    logic [DATA_WIDTH-1:0] expected;

    // An all-zero seed would lock the LFSR and stall the stream forever.
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("spoofer_avst_sink: LFSR_SEED must be nonzero");
    end

    // A clear in the same cycle as a beat drops the beat.
    assign accept = valid && ready && !clr;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; clr overrides everything.
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = ST_FLUSH;
        end else begin
            case (state)
                ST_SYNC:  if (accept) state_nxt = ST_CHECK;
                ST_CHECK: state_nxt = ST_CHECK;
                ST_FLUSH: state_nxt = ST_SYNC;
                default:  state_nxt = ST_SYNC;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        locked = (state == ST_CHECK);
    end

    // Registered ready: low in reset and during FLUSH, high one edge later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_ready <= 1'b0;
        end else begin
            state_ready <= !clr;
        end
    end

`ifdef SPOOFER_AVST_SINK_STALL_EN
    logic [15:0] lfsr;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11, reseeded on clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else if (clr) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign ready = state_ready && lfsr[0];
`else
    assign ready = state_ready;
`endif

    // Checker datapath: expected value, counters and first-error capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            expected      <= '0;
            beat_count    <= '0;
            error_count   <= '0;
            err_sticky    <= 1'b0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (clr) begin
            expected      <= '0;
            beat_count    <= '0;
            error_count   <= '0;
            err_sticky    <= 1'b0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (accept) begin
            if (beat_count != CNT_MAX) begin
                beat_count <= beat_count + 1'b1;
            end
            if (state == ST_CHECK && data == expected) begin
                expected <= expected + 1'b1;
            end else begin
                // First beat locks; a mismatch resyncs so one glitch counts once.
                expected <= data + 1'b1;
                if (state == ST_CHECK) begin
                    if (error_count != CNT_MAX) begin
                        error_count <= error_count + 1'b1;
                    end
                    if (!err_sticky) begin
                        err_sticky    <= 1'b1;
                        first_err_exp <= expected;
                        first_err_got <= data;
                    end
                end
            end
        end
    end

endmodule
